mips_mc_sequencer: RTL and testbench
====================================

// Module: mips_mc_sequencer
// PURPOSE
//  Owns the state register of the multi-cycle MIPS core. Decodes Op/Funct and drives all datapath controls
//  (Moore, from state). Sits between instruction register and datapath; stalls on unified-memory wait states.
//  Counts retired instructions and flags illegal opcodes and memory timeouts.
// PARAMETERS
//  CNT_W     32  width of retired-instruction counter (wraps modulo 2^CNT_W)
//  MAX_WAIT  15  max cycles a memory state may wait for mem_ready before bus_err; 0 = no timeout
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  Op          in   6      IR[31:26]
//  Funct       in   6      IR[5:0]
//  Zero        in   1      ALU zero flag
//  mem_ready   in   1      memory completes current access this cycle
//  mem_req     out  1      memory access in progress (FETCH, MEMRD, MEMWR)
//  MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite  out 1 each
//  PCEn        out  1      PCWrite | (Branch & Zero)
//  ALUSrcB     out  2      00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  PCSrc       out  2      00 ALUResult, 01 ALUOut, 10 jump target
//  ALUControl  out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
//  next_ins    out  1      1-cycle pulse in final cycle of each retired instruction
//  instr_count out  CNT_W  retired instructions
//  illegal_op  out  1      sticky: unsupported Op/Funct decoded
//  bus_err     out  1      sticky: MAX_WAIT exceeded
// BEHAVIOUR
//  Reset: state=FETCH, instr_count=0, wait_cnt=0, illegal_op=0, bus_err=0; while rst=1 all control outputs,
//   mem_req and next_ins forced 0 (rst overrides everything, including mid-instruction).
//  States/transitions:
//   FETCH  : IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00, mem_req=1; IRWrite=PCWrite=mem_ready.
//            Holds until mem_ready, then -> DECODE.
//   DECODE : ALUSrcA=0, ALUSrcB=11, add. Op 100011/101011->MEMADR, 000000->RTYPE, 001000->ADDIEX,
//            000100->BEQ, 000010->JUMP; other Op, or Op=0 with Funct not in {20,22,24,25,2A}h ->
//            set illegal_op, next_ins=1, ->FETCH (treated as NOP, counted).
//   MEMADR : ALUSrcA=1, ALUSrcB=10, add. lw->MEMRD, sw->MEMWR.
//   MEMRD  : IorD=1, mem_req=1; wait for mem_ready -> MEMWB.
//   MEMWB  : RegDst=0, MemToReg=1, RegWrite=1, next_ins=1 -> FETCH.
//   MEMWR  : IorD=1, mem_req=1, MemWrite=mem_ready; on mem_ready next_ins=1 -> FETCH.
//   RTYPE  : ALUSrcA=1, ALUSrcB=00, ALUControl from Funct -> ALUWB.
//   ALUWB  : RegDst=1, MemToReg=0, RegWrite=1, next_ins=1 -> FETCH.
//   ADDIEX : ALUSrcA=1, ALUSrcB=10, add -> ADDIWB.
//   ADDIWB : RegDst=0, MemToReg=0, RegWrite=1, next_ins=1 -> FETCH.
//   BEQ    : ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1, next_ins=1 -> FETCH.
//   JUMP   : PCSrc=10, PCWrite=1, next_ins=1 -> FETCH.
//  Unlisted controls are 0 in every state. Cycles: lw 5, sw 4, R/addi 4, beq/j 3 (+ wait cycles).
//  instr_count increments on the edge where next_ins=1; wraps all-ones -> 0 without flag.
//  wait_cnt counts consecutive mem_req cycles without mem_ready; clears on mem_ready or state change.
//   Reaching MAX_WAIT (if >0): set bus_err, abandon access (no IRWrite/MemWrite), ->FETCH, no next_ins.
//  Op/Funct sampled combinationally; they must be stable from DECODE to the final state (IR held).
//  Unreachable state encodings -> FETCH next cycle.
// STRUCTURE
//  Package mips_mc_pkg: state enum (4-bit), opcode/funct localparams, ALUControl and ALUSrcB/PCSrc encodings.
//  One sub-module: mips_alu_decoder (ALUOp[1:0] + Funct -> ALUControl, illegal_funct), combinational.
//  Top: state register, wait counter, instruction counter, sticky flags, Moore output decode.
// TESTING
//  1 rst 3 cycles, mem_ready=1, Op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite&MemToReg in
//    cycle 5, next_ins pulse once, instr_count=1.
//  2 Op=0, Funct=22h,2Ah,24h,25h,20h -> ALUControl 110,111,000,001,010 in RTYPE; RegDst=1 in ALUWB; 4 cycles.
//  3 Op=000100 with Zero=1 then Zero=0 -> PCEn=1 then 0 in BEQ; PCSrc=01; 3 cycles each.
//  4 Op=101011, mem_ready low 3 cycles in MEMWR -> MemWrite only in cycle mem_ready=1, stays MEMWR meanwhile.
//  5 MAX_WAIT=15, mem_ready held 0 in FETCH -> bus_err=1 after 15 cycles, state=FETCH, IRWrite never 1;
//    Op=111111 -> illegal_op=1, instr_count+1.
//  6 rst asserted in MEMRD -> next cycle FETCH, all counters/flags 0, no RegWrite issued.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BEQ    = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  // Per-state control word; alu_en selects whether the decoded ALUControl is driven.
  typedef struct packed {
    logic       mem_req;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       iord;
    logic       alu_src_a;
    logic       ir_write;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic       alu_en;
    logic       next_ins;
    alu_src_b_e alu_src_b;
    pc_src_e    pc_src;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
  endfunction

  function automatic logic funct_supported(input logic [5:0] funct);
    return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

endpackage

// File: rtl/mips_mc_sequencer_if.sv
// Instruction-register / datapath control bundle between the sequencer and the datapath.
interface mips_mc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             mem_ready;
  logic             mem_req;
  logic             MemToReg;
  logic             RegDst;
  logic             IorD;
  logic             ALUSrcA;
  logic             IRWrite;
  logic             MemWrite;
  logic             PCWrite;
  logic             Branch;
  logic             RegWrite;
  logic             PCEn;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSrc;
  logic [2:0]       ALUControl;
  logic             next_ins;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_op;
  logic             bus_err;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output mem_req, MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch,
           RegWrite, PCEn, ALUSrcB, PCSrc, ALUControl, next_ins, instr_count, illegal_op, bus_err
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  mem_req, MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch,
           RegWrite, PCEn, ALUSrcB, PCSrc, ALUControl, next_ins, instr_count, illegal_op, bus_err
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// ALUOp + Funct to ALUControl; illegal_funct reports an unsupported R-type function code.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal_funct
);

  assign illegal_funct = !funct_supported(funct);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control FSM: Moore datapath controls, memory wait/timeout,
// retired-instruction counter and sticky illegal-opcode / bus-error flags.
module mips_mc_sequencer
  import mips_mc_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input logic                 clk,
  input logic                 rst,
  mips_mc_sequencer_if.master bus
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               illegal_op_q, illegal_op_d;
  logic               bus_err_q, bus_err_d;

  ctrl_t      ctrl;
  alu_op_e    alu_op;
  logic [2:0] alu_ctrl_dec;
  logic       illegal_funct;
  logic       mem_state;
  logic       wait_timeout;
  logic       decode_illegal;

  assign alu_op = (state_q == S_RTYPE) ? ALUOP_FUNCT :
                  ((state_q == S_BEQ) ? ALUOP_SUB : ALUOP_ADD);

  mips_alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (bus.Funct),
    .alu_control   (alu_ctrl_dec),
    .illegal_funct (illegal_funct)
  );

  assign mem_state      = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
  // The MAX_WAIT-th consecutive unanswered cycle abandons the access.
  assign wait_timeout   = (MAX_WAIT > 0) && mem_state && !bus.mem_ready &&
                          (int'(wait_cnt_q) == MAX_WAIT - 1);
  assign decode_illegal = (state_q == S_DECODE) &&
                          (!op_supported(bus.Op) || (bus.Op == OP_RTYPE && illegal_funct));

  // NOTE: reset is synchronous, and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
      illegal_op_q  <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
      illegal_op_q  <= illegal_op_d;
      bus_err_q     <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = illegal_funct ? S_FETCH : S_RTYPE;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_RTYPE:  state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    if (wait_timeout) state_d = S_FETCH;

    wait_cnt_d = '0;
    if ((MAX_WAIT > 0) && mem_state && !bus.mem_ready && !wait_timeout) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    instr_count_d = ctrl.next_ins ? instr_count_q + 1'b1 : instr_count_q;
    illegal_op_d  = illegal_op_q | decode_illegal;
    bus_err_d     = bus_err_q | wait_timeout;
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_en    = 1'b1;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_en    = 1'b1;
        ctrl.next_ins  = decode_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_en    = 1'b1;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.mem_req = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.next_ins   = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = bus.mem_ready;
        ctrl.next_ins  = bus.mem_ready;
      end
      S_RTYPE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_en    = 1'b1;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.next_ins  = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.next_ins  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_en    = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
        ctrl.next_ins  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
        ctrl.next_ins = 1'b1;
      end
      default: ;
    endcase
    // Reset silences every control, even mid-instruction.
    if (rst) ctrl = '0;
  end

  assign bus.mem_req     = ctrl.mem_req;
  assign bus.MemToReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.IorD        = ctrl.iord;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.Branch      = ctrl.branch;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.PCEn        = ctrl.pc_write | (ctrl.branch & bus.Zero);
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.PCSrc       = ctrl.pc_src;
  assign bus.ALUControl  = ctrl.alu_en ? alu_ctrl_dec : 3'b000;
  assign bus.next_ins    = ctrl.next_ins;
  assign bus.instr_count = instr_count_q;
  assign bus.illegal_op  = illegal_op_q;
  assign bus.bus_err     = bus_err_q;

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Directed table-driven bench for mips_mc_sequencer, plus wrap, timeout and mid-instruction reset sequences.
module tb_mips_mc_sequencer;

  localparam int CNT_W = 4;

  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] SW  = 6'h2B;
  localparam logic [5:0] RT  = 6'h00;
  localparam logic [5:0] ADI = 6'h08;
  localparam logic [5:0] BQ  = 6'h04;
  localparam logic [5:0] JP  = 6'h02;
  localparam logic [5:0] BAD = 6'h3F;

  typedef enum {T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
                T_RTYPE, T_ALUWB, T_ADDIEX, T_ADDIWB, T_BEQ, T_JUMP} tst_e;

  typedef struct packed {
    logic       mem_req, mem_to_reg, reg_dst, iord, alu_src_a, ir_write, mem_write;
    logic       pc_write, branch, reg_write, pc_en;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_ctrl;
    logic       next_ins;
  } obs_t;

  typedef struct {
    bit         rst;
    logic [5:0] op;
    logic [5:0] funct;
    bit         zero;
    bit         rdy;
    tst_e       st;
    logic [2:0] alu;
    bit         ill;
    int         cnt;
    bit         illf;
    bit         berr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mips_mc_sequencer_if #(.CNT_W(CNT_W)) sif ();

  mips_mc_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  function automatic vec_t v(bit r, logic [5:0] op, logic [5:0] fn, bit z, bit rdy, tst_e st,
                             logic [2:0] alu, bit ill, int cnt, bit illf, bit berr);
    vec_t x;
    x.rst = r; x.op = op; x.funct = fn; x.zero = z; x.rdy = rdy; x.st = st;
    x.alu = alu; x.ill = ill; x.cnt = cnt; x.illf = illf; x.berr = berr;
    return x;
  endfunction

  // Expected control outputs for a state, written from the control table.
  function automatic obs_t exp_of(vec_t r);
    obs_t o = '0;
    case (r.st)
      T_FETCH:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
                      o.ir_write = r.rdy; o.pc_write = r.rdy; o.pc_en = r.rdy; end
      T_DECODE: begin o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; o.next_ins = r.ill; end
      T_MEMADR, T_ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
      T_MEMRD:  begin o.iord = 1; o.mem_req = 1; end
      T_MEMWB:  begin o.mem_to_reg = 1; o.reg_write = 1; o.next_ins = 1; end
      T_MEMWR:  begin o.iord = 1; o.mem_req = 1; o.mem_write = r.rdy; o.next_ins = r.rdy; end
      T_RTYPE:  begin o.alu_src_a = 1; o.alu_ctrl = r.alu; end
      T_ALUWB:  begin o.reg_dst = 1; o.reg_write = 1; o.next_ins = 1; end
      T_ADDIWB: begin o.reg_write = 1; o.next_ins = 1; end
      T_BEQ:    begin o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01; o.branch = 1;
                      o.pc_en = r.zero; o.next_ins = 1; end
      T_JUMP:   begin o.pc_src = 2'b10; o.pc_write = 1; o.pc_en = 1; o.next_ins = 1; end
      default:  ;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample just after, let the rising edge advance state.
  task automatic step(input string tag, input vec_t r);
    obs_t act;
    @(negedge clk);
    rst           = r.rst;
    sif.Op        = r.op;
    sif.Funct     = r.funct;
    sif.Zero      = r.zero;
    sif.mem_ready = r.rdy;
    #1;
    act = '{sif.mem_req, sif.MemToReg, sif.RegDst, sif.IorD, sif.ALUSrcA, sif.IRWrite,
            sif.MemWrite, sif.PCWrite, sif.Branch, sif.RegWrite, sif.PCEn, sif.ALUSrcB,
            sif.PCSrc, sif.ALUControl, sif.next_ins};
    check({tag, " ctrl"}, 32'(act), 32'(exp_of(r)));
    check({tag, " cnt/flags"}, {26'd0, sif.instr_count, sif.illegal_op, sif.bus_err},
          {26'd0, 4'(r.cnt), r.illf, r.berr});
  endtask

  vec_t tbl[$];

  initial begin
    sif.Op = '0; sif.Funct = '0; sif.Zero = 1'b0; sif.mem_ready = 1'b1;

    // rst, op, funct, zero, rdy, state, alu, ill, cnt, illf, berr
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, LW, 0, 0, 1, T_RST, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, LW, 0, 0, 1, T_FETCH,  0, 0, 0, 0, 0));
    tbl.push_back(v(0, LW, 0, 0, 1, T_DECODE, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, LW, 0, 0, 1, T_MEMADR, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, LW, 0, 0, 1, T_MEMRD,  0, 0, 0, 0, 0));
    tbl.push_back(v(0, LW, 0, 0, 1, T_MEMWB,  0, 0, 0, 0, 0));
    tbl.push_back(v(0, RT, 6'h22, 0, 1, T_FETCH,  0, 0, 1, 0, 0));
    tbl.push_back(v(0, RT, 6'h22, 0, 1, T_DECODE, 0, 0, 1, 0, 0));
    tbl.push_back(v(0, RT, 6'h22, 0, 1, T_RTYPE, 3'b110, 0, 1, 0, 0));
    tbl.push_back(v(0, RT, 6'h22, 0, 1, T_ALUWB,  0, 0, 1, 0, 0));
    tbl.push_back(v(0, RT, 6'h2A, 0, 1, T_FETCH,  0, 0, 2, 0, 0));
    tbl.push_back(v(0, RT, 6'h2A, 0, 1, T_DECODE, 0, 0, 2, 0, 0));
    tbl.push_back(v(0, RT, 6'h2A, 0, 1, T_RTYPE, 3'b111, 0, 2, 0, 0));
    tbl.push_back(v(0, RT, 6'h2A, 0, 1, T_ALUWB,  0, 0, 2, 0, 0));
    tbl.push_back(v(0, RT, 6'h24, 0, 1, T_FETCH,  0, 0, 3, 0, 0));
    tbl.push_back(v(0, RT, 6'h24, 0, 1, T_DECODE, 0, 0, 3, 0, 0));
    tbl.push_back(v(0, RT, 6'h24, 0, 1, T_RTYPE, 3'b000, 0, 3, 0, 0));
    tbl.push_back(v(0, RT, 6'h24, 0, 1, T_ALUWB,  0, 0, 3, 0, 0));
    tbl.push_back(v(0, RT, 6'h25, 0, 1, T_FETCH,  0, 0, 4, 0, 0));
    tbl.push_back(v(0, RT, 6'h25, 0, 1, T_DECODE, 0, 0, 4, 0, 0));
    tbl.push_back(v(0, RT, 6'h25, 0, 1, T_RTYPE, 3'b001, 0, 4, 0, 0));
    tbl.push_back(v(0, RT, 6'h25, 0, 1, T_ALUWB,  0, 0, 4, 0, 0));
    tbl.push_back(v(0, RT, 6'h20, 0, 1, T_FETCH,  0, 0, 5, 0, 0));
    tbl.push_back(v(0, RT, 6'h20, 0, 1, T_DECODE, 0, 0, 5, 0, 0));
    tbl.push_back(v(0, RT, 6'h20, 0, 1, T_RTYPE, 3'b010, 0, 5, 0, 0));
    tbl.push_back(v(0, RT, 6'h20, 0, 1, T_ALUWB,  0, 0, 5, 0, 0));
    tbl.push_back(v(0, BQ, 0, 1, 1, T_FETCH,  0, 0, 6, 0, 0));
    tbl.push_back(v(0, BQ, 0, 1, 1, T_DECODE, 0, 0, 6, 0, 0));
    tbl.push_back(v(0, BQ, 0, 1, 1, T_BEQ,    0, 0, 6, 0, 0));
    tbl.push_back(v(0, BQ, 0, 0, 1, T_FETCH,  0, 0, 7, 0, 0));
    tbl.push_back(v(0, BQ, 0, 0, 1, T_DECODE, 0, 0, 7, 0, 0));
    tbl.push_back(v(0, BQ, 0, 0, 1, T_BEQ,    0, 0, 7, 0, 0));
    tbl.push_back(v(0, ADI, 0, 0, 1, T_FETCH,  0, 0, 8, 0, 0));
    tbl.push_back(v(0, ADI, 0, 0, 1, T_DECODE, 0, 0, 8, 0, 0));
    tbl.push_back(v(0, ADI, 0, 0, 1, T_ADDIEX, 0, 0, 8, 0, 0));
    tbl.push_back(v(0, ADI, 0, 0, 1, T_ADDIWB, 0, 0, 8, 0, 0));
    tbl.push_back(v(0, JP, 0, 0, 1, T_FETCH,  0, 0, 9, 0, 0));
    tbl.push_back(v(0, JP, 0, 0, 1, T_DECODE, 0, 0, 9, 0, 0));
    tbl.push_back(v(0, JP, 0, 0, 1, T_JUMP,   0, 0, 9, 0, 0));
    tbl.push_back(v(0, SW, 0, 0, 0, T_FETCH,  0, 0, 10, 0, 0));
    tbl.push_back(v(0, SW, 0, 0, 0, T_FETCH,  0, 0, 10, 0, 0));
    tbl.push_back(v(0, SW, 0, 0, 1, T_FETCH,  0, 0, 10, 0, 0));
    tbl.push_back(v(0, SW, 0, 0, 1, T_DECODE, 0, 0, 10, 0, 0));
    tbl.push_back(v(0, SW, 0, 0, 1, T_MEMADR, 0, 0, 10, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, SW, 0, 0, 0, T_MEMWR, 0, 0, 10, 0, 0));
    tbl.push_back(v(0, SW, 0, 0, 1, T_MEMWR,  0, 0, 10, 0, 0));
    tbl.push_back(v(0, BAD, 0, 0, 1, T_FETCH,  0, 0, 11, 0, 0));
    tbl.push_back(v(0, BAD, 0, 0, 1, T_DECODE, 0, 1, 11, 0, 0));
    tbl.push_back(v(0, RT, 6'h3F, 0, 1, T_FETCH,  0, 0, 12, 1, 0));
    tbl.push_back(v(0, RT, 6'h3F, 0, 1, T_DECODE, 0, 1, 12, 1, 0));
    tbl.push_back(v(0, JP, 0, 0, 1, T_FETCH,  0, 0, 13, 1, 0));
    tbl.push_back(v(0, JP, 0, 0, 1, T_DECODE, 0, 0, 13, 1, 0));
    tbl.push_back(v(0, JP, 0, 0, 1, T_JUMP,   0, 0, 13, 1, 0));

    for (int i = 0; i < tbl.size(); i++) step($sformatf("row%0d", i), tbl[i]);

    // Counter wrap: 4-bit count goes 14 -> 15 -> 0 with no flag.
    for (int k = 0; k < 2; k++) begin
      step($sformatf("wrap%0d_f", k), v(0, JP, 0, 0, 1, T_FETCH,  0, 0, 14 + k, 1, 0));
      step($sformatf("wrap%0d_d", k), v(0, JP, 0, 0, 1, T_DECODE, 0, 0, 14 + k, 1, 0));
      step($sformatf("wrap%0d_j", k), v(0, JP, 0, 0, 1, T_JUMP,   0, 0, 14 + k, 1, 0));
    end

    // Fetch timeout: 15 unanswered cycles, then bus_err and still in FETCH with no IRWrite.
    for (int k = 0; k < 15; k++)
      step($sformatf("tmo%0d", k), v(0, BAD, 0, 0, 0, T_FETCH, 0, 0, 0, 1, 0));
    step("tmo_err",   v(0, BAD, 0, 0, 0, T_FETCH,  0, 0, 0, 1, 1));
    step("tmo_fetch", v(0, BAD, 0, 0, 1, T_FETCH,  0, 0, 0, 1, 1));
    step("tmo_bad",   v(0, BAD, 0, 0, 1, T_DECODE, 0, 1, 0, 1, 1));

    // Reset while waiting in MEMRD: no writeback, everything cleared.
    step("rmd_f",   v(0, LW, 0, 0, 1, T_FETCH,  0, 0, 1, 1, 1));
    step("rmd_d",   v(0, LW, 0, 0, 1, T_DECODE, 0, 0, 1, 1, 1));
    step("rmd_a",   v(0, LW, 0, 0, 1, T_MEMADR, 0, 0, 1, 1, 1));
    step("rmd_rd",  v(0, LW, 0, 0, 0, T_MEMRD,  0, 0, 1, 1, 1));
    step("rmd_rst", v(1, LW, 0, 0, 1, T_RST,    0, 0, 1, 1, 1));
    step("rmd_out", v(0, LW, 0, 0, 0, T_FETCH,  0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
